mem_result_checker: RTL and testbench

MEM_RESULT_CHECKER -- requirements
Module: mem_result_checker

---
 rtl/mem_result_checker.sv | 139 +++++++++++++
 tb/tb_mem_result_checker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_result_checker.sv
// Watches memory writes to NCHAN result locations over a fixed window and reports pass/fail.
// Optional macro CHK_EARLY_EXIT_EN: finish as soon as every location holds its expected value.

module mem_result_checker_lane #(
  parameter int                ADDR_W = 16,
  parameter int                DATA_W = 8,
  parameter logic [ADDR_W-1:0] ADDR   = '0,
  parameter logic [DATA_W-1:0] DATA   = '0
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              clr,
  input  logic              run,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] last_val,
  output logic              fail
);
  logic              seen, hit, seen_nxt;
  logic [DATA_W-1:0] val_nxt;

  // Verdict is taken from next-state values so a write in the closing cycle still counts.
  always_comb begin
    hit      = run & mem_we & (mem_addr == ADDR);
    seen_nxt = seen | hit;
    val_nxt  = hit ? mem_wdata : last_val;
    fail     = !seen_nxt || (val_nxt != DATA);
  end

  always_ff @(posedge ph1) begin
    if (reset || clr) begin
      seen     <= 1'b0;
      last_val <= '0;
    end else begin
      seen     <= seen_nxt;
      last_val <= val_nxt;
    end
  end
endmodule

module mem_result_checker #(
  parameter int                       NCHAN      = 2,
  parameter int                       ADDR_W     = 16,
  parameter int                       DATA_W     = 8,
  parameter int                       RUN_CYCLES = 200,
  parameter logic [NCHAN*ADDR_W-1:0]  CHK_ADDR   = {16'h0031, 16'h0030},
  parameter logic [NCHAN*DATA_W-1:0]  CHK_DATA   = {8'h55, 8'hCE},
  localparam int                      SEL_W      = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int                      CNT_W      = $clog2(RUN_CYCLES + 1)
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NCHAN-1:0]  fail_mask,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [DATA_W-1:0] rd_val
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  logic [1:0]                   state;
  logic                         run, clr, last, early;
  logic [NCHAN-1:0]             fail_nxt;
  logic [NCHAN-1:0][DATA_W-1:0] last_val;

  assign run  = (state == S_RUN);
  assign clr  = start && !run;
  assign last = (cycle_count == CNT_W'(RUN_CYCLES - 1));

`ifdef CHK_EARLY_EXIT_EN
  assign early = ~|fail_nxt;
`else
  assign early = 1'b0;
`endif

  for (genvar i = 0; i < NCHAN; i++) begin : g_lane
    mem_result_checker_lane #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .ADDR   (CHK_ADDR[i*ADDR_W +: ADDR_W]),
      .DATA   (CHK_DATA[i*DATA_W +: DATA_W])
    ) u_lane (
      .ph1       (ph1),
      .reset     (reset),
      .clr       (clr),
      .run       (run),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .last_val  (last_val[i]),
      .fail      (fail_nxt[i])
    );
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      state       <= S_IDLE;
      cycle_count <= '0;
      fail_mask   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          cycle_count <= cycle_count + CNT_W'(1);
          if (last || early) begin
            state     <= (|fail_nxt) ? S_FAIL : S_PASS;
            fail_mask <= fail_nxt;
          end
        end
        default: begin
          if (start) begin
            state       <= S_RUN;
            cycle_count <= '0;
            fail_mask   <= '0;
          end
        end
      endcase
    end
  end

  assign busy = run;
  assign done = (state == S_PASS) || (state == S_FAIL);
  assign pass = (state == S_PASS);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NCHAN; i++)
      if (rd_sel == SEL_W'(i)) rd_val = last_val[i];
  end
endmodule

// File: tb/tb_mem_result_checker.sv
// Directed bench for mem_result_checker at default parameters.
module tb_mem_result_checker;
  logic        ph1 = 1'b0;
  logic        reset, start, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [0:0]  rd_sel;
  logic        busy, done, pass;
  logic [1:0]  fail_mask;
  logic [7:0]  cycle_count;
  logic [7:0]  rd_val;

  int nvec = 0;
  int nerr = 0;

`ifdef CHK_EARLY_EXIT_EN
  localparam int PASS_CNT = 21;
`else
  localparam int PASS_CNT = 200;
`endif

  mem_result_checker dut (
    .ph1(ph1), .reset(reset), .start(start), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rd_sel(rd_sel),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
    .cycle_count(cycle_count), .rd_val(rd_val)
  );

  always #5 ph1 = ~ph1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic advance_to(input int k);
    int n = 0;
    while (busy && cycle_count < 8'(k) && n < 300) begin
      tick();
      n++;
    end
    chk("advance", cycle_count, k);
  endtask

  task automatic write_at(input int k, input logic [15:0] a, input logic [7:0] d);
    advance_to(k);
    mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    chk("done_timeout", done, 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic s, input logic [7:0] exp);
    rd_sel = s;
    #1;
    chk(tag, rd_val, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; rd_sel = '0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mask", fail_mask, 0);
    chk("rst_cnt", cycle_count, 0);
    chk_rd("rst_rd0", 1'b0, 8'h00);

    // correct writes at cycles 10 and 20
    do_start();
    chk("t1_busy", busy, 1);
    chk("t1_cnt0", cycle_count, 0);
    write_at(10, 16'h0030, 8'hCE);
    write_at(20, 16'h0031, 8'h55);
    wait_done();
    chk("t1_pass", pass, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_mask", fail_mask, 2'b00);
    chk("t1_cnt", cycle_count, PASS_CNT);
    mem_we = 1'b1; mem_addr = 16'h0030; mem_wdata = 8'h00;
    tick(); tick();
    mem_we = 1'b0;
    chk("t1_cnt_hold", cycle_count, PASS_CNT);
    chk("t1_pass_hold", pass, 1);
    chk_rd("t1_rd0_nowrite", 1'b0, 8'hCE);
    chk_rd("t1_rd1", 1'b1, 8'h55);

    // overwrite on ch0 (last wins), wrong value on ch1
    do_start();
    chk_rd("t2_rd0_clr", 1'b0, 8'h00);
    chk("t2_mask_clr", fail_mask, 0);
    write_at(5, 16'h0030, 8'h12);
    write_at(6, 16'h0030, 8'hCE);
    write_at(7, 16'h0031, 8'h54);
    wait_done();
    chk("t2_pass", pass, 0);
    chk("t2_mask", fail_mask, 2'b10);
    chk("t2_cnt", cycle_count, 200);
    chk_rd("t2_rd0", 1'b0, 8'hCE);
    chk_rd("t2_rd1", 1'b1, 8'h54);

    // ch0 written in final window cycle, ch1 never written
    do_start();
    write_at(199, 16'h0030, 8'hCE);
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    chk("t3_mask", fail_mask, 2'b10);
    chk("t3_cnt", cycle_count, 200);
    chk_rd("t3_rd0", 1'b0, 8'hCE);

    // reset mid-window, then a clean window
    do_start();
    write_at(10, 16'h0030, 8'hCE);
    advance_to(50);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_cnt", cycle_count, 0);
    chk("t4_mask", fail_mask, 0);
    chk_rd("t4_rd0", 1'b0, 8'h00);
    do_start();
    write_at(10, 16'h0030, 8'hCE);
    write_at(20, 16'h0031, 8'h55);
    wait_done();
    chk("t4_pass", pass, 1);
    chk("t4_mask2", fail_mask, 0);

    // pre-start writes ignored, start held through the window
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_we = 1'b1; mem_addr = 16'h0030; mem_wdata = 8'hCE;
    tick();
    mem_addr = 16'h0031; mem_wdata = 8'h55;
    tick();
    mem_we = 1'b0;
    start = 1'b1;
    tick();
    advance_to(100);
    chk("t5_busy", busy, 1);
    wait_done();
    start = 1'b0;
    chk("t5_pass", pass, 0);
    chk("t5_mask", fail_mask, 2'b11);
    chk("t5_cnt", cycle_count, 200);
    chk_rd("t5_rd0", 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
